// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Round-robin arbitration is selected with the ALU_ARB_RR_EN macro.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_ADD_ALT = 3'b100;
  localparam logic [2:0] OP_SUB_ALT = 3'b101;
  localparam logic [2:0] OP_MOV     = 3'b110;
  localparam logic [2:0] OP_XOR     = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// Bit i of each 2-bit vector belongs to requester i.
interface alu_arbiter_if #(parameter int N = 32);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [2:0]   req0_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [2:0]   req1_op;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU owned by alu_arbiter; flags are {N, Z, C, V}.
// C on subtract means "no borrow" (carry out of a + ~b + 1).
module alu
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  logic [N:0]   sum_s;
  logic [N:0]   diff_s;
  logic [N-1:0] res_s;
  logic         carry_s;
  logic         ovf_s;

  // Operation decode with carry/overflow for the arithmetic ops
  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    diff_s  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    res_s   = {N{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      OP_ADD, OP_ADD_ALT: begin
        res_s   = sum_s[N-1:0];
        carry_s = sum_s[N];
        ovf_s   = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
      end
      OP_SUB, OP_SUB_ALT: begin
        res_s   = diff_s[N-1:0];
        carry_s = diff_s[N];
        ovf_s   = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
      end
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_MOV:  res_s = b;
      OP_XOR:  res_s = a ^ b;
      default: res_s = {N{1'b0}};
    endcase
  end

  // Flag packing from the selected result
  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = res_s[N-1];
    flags[FLAG_Z] = (res_s == {N{1'b0}});
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

  assign result = res_s;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_t   state_r;
  arb_state_t   state_s;
  logic         win_s;
  logic         accept_s;
  logic         done_s;
  logic [1:0]   req_ready_s;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic [2:0]   op_r;
  logic         gnt_r;
  logic [N-1:0] alu_res_s;
  logic [3:0]   alu_flg_s;
  logic [N-1:0] result_r;
  logic [3:0]   flags_r;
  logic [1:0]   rsp_valid_r;

`ifdef ALU_ARB_RR_EN
  logic         last_r;

  // Winner selection: on contention the requester not granted last wins
  always_comb begin
    if (bus.req_valid == 2'b11) begin
      win_s = ~last_r;
    end else if (bus.req_valid[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // Last-grant register, starts at 1 so requester 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (accept_s) begin
      last_r <= win_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  // Winner selection: requester 0 always has priority
  always_comb begin
    if (bus.req_valid[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`endif

  // Next-state and handshake decode
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    req_ready_s = 2'b00;
    case (state_r)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          accept_s    = 1'b1;
          req_ready_s = win_s ? 2'b10 : 2'b01;
          state_s     = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        // Only the granted requester's rsp_ready can complete the transfer
        if (bus.rsp_ready[gnt_r]) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture for the granted requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r   <= {N{1'b0}};
      b_r   <= {N{1'b0}};
      op_r  <= 3'b000;
      gnt_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= win_s ? bus.req1_a  : bus.req0_a;
      b_r   <= win_s ? bus.req1_b  : bus.req0_b;
      op_r  <= win_s ? bus.req1_op : bus.req0_op;
      gnt_r <= win_s;
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      op_r  <= op_r;
      gnt_r <= gnt_r;
    end
  end

  alu #(.N(N)) u_alu (
    .a      (a_r),
    .b      (b_r),
    .op     (op_r),
    .result (alu_res_s),
    .flags  (alu_flg_s)
  );

  // Response registers: loaded at the end of EXEC, held after transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r    <= {N{1'b0}};
      flags_r     <= 4'b0000;
      rsp_valid_r <= 2'b00;
    end else if (state_r == EXEC) begin
      result_r    <= alu_res_s;
      flags_r     <= alu_flg_s;
      rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
    end else if (done_s) begin
      result_r    <= result_r;
      flags_r     <= flags_r;
      rsp_valid_r <= 2'b00;
    end else begin
      result_r    <= result_r;
      flags_r     <= flags_r;
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = result_r;
  assign bus.rsp_flags  = flags_r;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters, for example the main datapath and a coprocessor or debug port. Each request carries two operands and a 3-bit operation code and uses a valid/ready handshake. The block grants one request at a time, registers the operands, runs them through the ALU, and holds the registered result and flags until the granted requester accepts them. It sits beside the datapath as the ALU's only owner.

## Interface
- `N`, default 32: operand and result width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester request accept; at most one bit high at a time.
- `req0_a`, `req0_b`  in  N  requester 0 operands.
- `req0_op`  in  3  requester 0 operation code.
- `req1_a`, `req1_b`  in  N  requester 1 operands.
- `req1_op`  in  3  requester 1 operation code.
- `rsp_valid`  out  2  response valid, one-hot to the granted requester.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_result`  out  N  registered ALU result, shared by both requesters.
- `rsp_flags`  out  4  registered flags {N, Z, C, V}, bit 3 down to bit 0.

## Operation
- Operation codes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 110 MOV (result = B), 111 XOR.
  - 100 and 101 pass through unchanged and behave as ADD and SUB.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - If any `req_valid` bit is high, the arbiter picks a winner g and drives `req_ready[g]`=1 combinationally in the same cycle.
  - On that edge it captures `reqg_a`, `reqg_b`, `reqg_op` and g, then moves to EXEC.
  - If no request is valid, the FSM stays in IDLE and `req_ready`=00.
- EXEC:
  - The captured operands drive the `alu`.
  - At the end of the cycle the result and flags are registered into `rsp_result`/`rsp_flags`, and the FSM moves to RESP.
- RESP:
  - `rsp_valid[g]`=1.
  - When `rsp_ready[g]`=1 the response transfers and the FSM returns to IDLE.
  - `rsp_ready` from the non-granted requester is ignored.
- `req_ready`=00 in EXEC and RESP. No new request is accepted until the current response transfers.
- Requesters hold their operands and op stable while `req_valid` is high. A requester may drop `req_valid` before being granted; nothing is captured for it.
- `rsp_result`/`rsp_flags` keep their last value after the transfer until the next EXEC.
- Reset mid-operation: the FSM returns to IDLE and the in-flight request is lost without a response.

## Timing
- Reset values:
  - `req_ready`=00, `rsp_valid`=00.
  - `rsp_result`=0, `rsp_flags`=0000.
  - FSM in IDLE, last-grant register = 1, so requester 0 wins first.
- Latency: request accepted at edge t → EXEC in cycle t+1 → `rsp_valid` high in cycle t+2.
- Throughput: at most one operation every 3 cycles (IDLE, EXEC, RESP), more if `rsp_ready` stalls.
- Simultaneous requests: resolved in a single IDLE cycle according to the arbitration policy (see Configuration).
- The ALU path is combinational inside EXEC only. Outputs never depend combinationally on requester operands.

## Configuration
- Macro `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - When both requesters are valid, the one not granted last wins.
  - The last-grant register updates on every accept.
- Undefined: fixed priority, requester 0 always wins.
  - No last-grant register is built.
  - Requester 1 may starve.

## Structure
- Package `alu_arb_pkg` holds:
  - State enum `arb_state_t` {IDLE, EXEC, RESP}.
  - Op localparams `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_MOV`, `OP_XOR`.
  - Flag index localparams `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One sub-module: `alu #(N)`, instantiated once. Its inputs come from the operand registers and its outputs feed the response registers.

## Test plan
- Requester 0, ADD, a=5, b=3, `rsp_ready`=1:
  - `req_ready`=01 in the accept cycle.
  - 2 cycles later `rsp_valid`=01, result 8, flags 0000.
- Requester 1, SUB, a=3, b=3: result 0, flags 0110 (Z and C set).
- ADD, a=0x7FFFFFFF, b=1: result 0x80000000, flags 1001 (N and V set).
- Both requesters valid continuously with `ALU_ARB_RR_EN`:
  - Grants alternate 0, 1, 0, 1.
  - Without the macro, all grants go to requester 0.
- `rsp_ready` held low for 5 cycles in RESP:
  - `rsp_valid`, result and flags stay stable, `req_ready` stays 00.
  - Transfer happens on the cycle `rsp_ready` rises.
- `reset` pulsed low during EXEC:
  - All outputs go to their reset values immediately.
  - No response is issued.
  - The next grant goes to requester 0.
